// File: rtl/ctrl_pkg.sv
// Shared definitions for the time-field adjuster and the display path.
// Holds the FSM state encodings, the BCD widths, the binary value width and
// a small BCD digit validity helper.
package ctrl_pkg;

    // FSM state encodings
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_REQ  = 1'b1;

    // BCD layout: two 4-bit digits, tens in the upper nibble
    localparam int DIGIT_W = 4;
    localparam int BCD_W   = 8;

    // Binary value width (covers 0..99)
    localparam int VAL_W = 7;

    // True when a 4-bit nibble is a legal decimal digit
    function automatic logic bcd_digit_ok(input logic [DIGIT_W-1:0] digit);
        return (digit <= 4'd9);
    endfunction

endpackage

// File: rtl/bin2bcd_2d.sv
// Combinational 7-bit binary to two-digit BCD converter.
// Ports:
//   bin_i   : binary value, expected range 0..99
//   tens_o  : tens digit
//   units_o : units digit
module bin2bcd_2d
    import ctrl_pkg::*;
(
    input  logic [VAL_W-1:0]   bin_i,
    output logic [DIGIT_W-1:0] tens_o,
    output logic [DIGIT_W-1:0] units_o
);

    logic [VAL_W-1:0]   rem_s;
    logic [DIGIT_W-1:0] tens_s;

    // Repeated subtraction of ten; twelve steps cover the full 7-bit input
    always_comb begin
        rem_s  = bin_i;
        tens_s = 4'd0;
        for (int i = 0; i < 12; i++) begin
            if (rem_s >= 7'd10) begin
                rem_s  = rem_s - 7'd10;
                tens_s = tens_s + 4'd1;
            end else begin
                rem_s  = rem_s;
            end
        end
    end

    assign tens_o  = tens_s;
    assign units_o = rem_s[DIGIT_W-1:0];

endmodule

// File: rtl/ctrl_ajuste_valor.sv
// Tick-driven adjuster of a bounded, wrap-around time field.
// Up/down ticks change the value by one (wrapping between MIN_VAL and
// MAX_VAL) and raise a write request that is held until acknowledged.
// A valid BCD load overrides everything and never raises a request.
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   en                  : adjustment enable for ticks
//   ticku, tickd        : single-cycle up/down ticks
//   load, load_bcd      : load strobe and BCD value to load
//   wr_ack              : acknowledge of wr_req
//   valor_bcd           : current value in BCD (combinational from register)
//   wr_req, busy        : registered request / REQ-state indication
module ctrl_ajuste_valor
    import ctrl_pkg::*;
#(
    parameter int MAX_VAL = 59,
    parameter int MIN_VAL = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             ticku,
    input  logic             tickd,
    input  logic             load,
    input  logic [BCD_W-1:0] load_bcd,
    input  logic             wr_ack,
    output logic [BCD_W-1:0] valor_bcd,
    output logic             wr_req,
    output logic             busy
);

    localparam logic [VAL_W-1:0] MAX_V = VAL_W'(MAX_VAL);
    localparam logic [VAL_W-1:0] MIN_V = VAL_W'(MIN_VAL);

    logic [0:0]       state_q, state_d;
    logic [VAL_W-1:0] val_q, val_d;
    logic             wr_req_q, busy_q;

    logic [DIGIT_W-1:0] ld_tens_s, ld_units_s;
    logic [7:0]         ld_bin_s;
    logic               ld_ok_s;
    logic [DIGIT_W-1:0] tens_s, units_s;

    // Decode the load value: tens*10+units, accepted only if both digits are
    // decimal and the result lies inside the field range
    always_comb begin
        ld_tens_s  = load_bcd[7:4];
        ld_units_s = load_bcd[3:0];
        ld_bin_s   = ({4'd0, ld_tens_s} * 8'd10) + {4'd0, ld_units_s};
        ld_ok_s    = bcd_digit_ok(ld_tens_s) && bcd_digit_ok(ld_units_s) &&
                     (ld_bin_s >= 8'(MIN_VAL)) && (ld_bin_s <= 8'(MAX_VAL));
    end

    // Next-state and next-value logic; a valid load takes priority
    always_comb begin
        state_d = state_q;
        val_d   = val_q;
        if (load && ld_ok_s) begin
            val_d   = ld_bin_s[VAL_W-1:0];
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (en && ticku && !tickd) begin
                        val_d   = (val_q >= MAX_V) ? MIN_V : (val_q + 7'd1);
                        state_d = ST_REQ;
                    end else if (en && tickd && !ticku) begin
                        val_d   = (val_q <= MIN_V) ? MAX_V : (val_q - 7'd1);
                        state_d = ST_REQ;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_REQ: begin
                    // Ticks are dropped while waiting for the acknowledge
                    if (wr_ack) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_REQ;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State, value and registered request outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            val_q    <= MIN_V;
            wr_req_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            val_q    <= val_d;
            wr_req_q <= (state_d == ST_REQ);
            busy_q   <= (state_d == ST_REQ);
        end
    end

    bin2bcd_2d u_bin2bcd (
        .bin_i   (val_q),
        .tens_o  (tens_s),
        .units_o (units_s)
    );

    assign valor_bcd = {tens_s, units_s};
    assign wr_req    = wr_req_q;
    assign busy      = busy_q;

endmodule
